// File: rtl/boxhead_param_fetch_master_pkg.sv
// Shared types and constants for the parameter-fetch Avalon-MM master.
package boxhead_fetch_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned FRAME_W = 16;
    localparam logic [3:0]  BE_ALL  = 4'hF;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, COMMIT} state_e;

    // Word address for fetch slot idx, wrapping within the WORDS-deep memory.
    function automatic int unsigned wrap_addr(input int unsigned base, input int unsigned idx,
                                              input int unsigned words);
        return (base + idx) % words;
    endfunction

endpackage

// File: rtl/boxhead_param_fetch_master_if.sv
// Avalon-MM bus between the fetch master and the parameter memory's hardware-side port.
interface boxhead_param_fetch_master_if #(
    parameter int unsigned WORDS = 4
);
    import boxhead_fetch_pkg::*;

    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [AW-1:0]     avm_address;
    logic              avm_chipselect;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [WORD_W-1:0] avm_writedata;
    logic [WORD_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/boxhead_param_fetch_master.sv
// Fetches WORDS parameter words per trigger and publishes them atomically on params.
// Optional completion write-back of the frame count: define BOXHEAD_FETCH_WRITEBACK_EN.
module boxhead_param_fetch_master
    import boxhead_fetch_pkg::*;
#(
    parameter int unsigned WORDS        = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    boxhead_param_fetch_master_if.master avm,
    output logic [WORDS*WORD_W-1:0]   params,
    output logic                      params_valid,
    output logic                      busy,
    output logic [FRAME_W-1:0]        frame_count
);

    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef BOXHEAD_FETCH_WRITEBACK_EN
    localparam bit          WB_EN = 1'b1;
    localparam int unsigned NREAD = WORDS - 1;
`else
    localparam bit          WB_EN = 1'b0;
    localparam int unsigned NREAD = WORDS;
`endif
    localparam logic [AW-1:0] WB_ADDR = AW'(wrap_addr(BASE_ADDR, WORDS - 1, WORDS));

    state_e                   state_q;
    logic [AW-1:0]            idx_q;
    logic [2:0]               lat_q;
    logic                     pending_q;
    logic [WORD_W-1:0]        staging_q [WORDS];
    logic [AW-1:0]            addr_q;
    logic                     cs_q, rd_q, wr_q;
    logic [WORD_W-1:0]        wdata_q;
    logic [WORDS*WORD_W-1:0]  params_q;
    logic                     valid_q;
    logic [FRAME_W-1:0]       frame_q;
    logic [FRAME_W-1:0]       frame_next;
    logic [WORDS*WORD_W-1:0]  commit_data;

    assign frame_next = frame_q + 1'b1;

    // The last word arrives on the commit edge itself, so it bypasses staging.
    always_comb begin
        commit_data = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            commit_data[i*WORD_W +: WORD_W] = staging_q[i];
        end
        if (WB_EN) begin
            commit_data[(WORDS-1)*WORD_W +: WORD_W] = WORD_W'(frame_next);
        end else begin
            commit_data[(WORDS-1)*WORD_W +: WORD_W] = avm.avm_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            lat_q     <= '0;
            pending_q <= 1'b0;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            params_q  <= '0;
            valid_q   <= 1'b0;
            frame_q   <= '0;
            for (int i = 0; i < int'(WORDS); i++) begin
                staging_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (start && state_q != IDLE) begin
                pending_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start || pending_q) begin
                        pending_q <= 1'b0;
                        idx_q     <= '0;
                        cs_q      <= 1'b1;
                        if (NREAD == 0) begin
                            state_q <= WB;
                            wr_q    <= 1'b1;
                            addr_q  <= WB_ADDR;
                            wdata_q <= WORD_W'(frame_next);
                        end else begin
                            state_q <= REQ;
                            rd_q    <= 1'b1;
                            addr_q  <= AW'(wrap_addr(BASE_ADDR, 0, WORDS));
                        end
                    end
                end
                REQ: begin
                    if (!avm.avm_waitrequest) begin
                        state_q <= WAIT;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        lat_q   <= 3'(READ_LATENCY);
                    end
                end
                WAIT: begin
                    if (lat_q == 3'd1) begin
                        staging_q[idx_q] <= avm.avm_readdata;
                        idx_q            <= idx_q + 1'b1;
                        if (idx_q == AW'(NREAD - 1)) begin
                            if (WB_EN) begin
                                state_q <= WB;
                                cs_q    <= 1'b1;
                                wr_q    <= 1'b1;
                                addr_q  <= WB_ADDR;
                                wdata_q <= WORD_W'(frame_next);
                            end else begin
                                state_q  <= COMMIT;
                                params_q <= commit_data;
                                valid_q  <= 1'b1;
                                frame_q  <= frame_next;
                            end
                        end else begin
                            state_q <= REQ;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= AW'(wrap_addr(BASE_ADDR, int'(idx_q) + 1, WORDS));
                        end
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                WB: begin
                    if (!avm.avm_waitrequest) begin
                        state_q  <= COMMIT;
                        cs_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        params_q <= commit_data;
                        valid_q  <= 1'b1;
                        frame_q  <= frame_next;
                    end
                end
                COMMIT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_byteenable = BE_ALL;
    assign avm.avm_write      = WB_EN ? wr_q : 1'b0;
    assign avm.avm_writedata  = WB_EN ? wdata_q : '0;

    assign params       = params_q;
    assign params_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign frame_count  = frame_q;

endmodule
